clock_display_scan: RTL and testbench

// - Downstream of the clock/calendar counter: takes its packed BCD time/date digits and drives one

---
 rtl/clock_display_scan.sv | 234 +++++++++++++++++++++++
 tb/tb_clock_display_scan.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// clock_display_scan: scans a once-per-frame snapshot of packed BCD time/date digits
// onto an 8-digit common-segment 7-segment display, with a debounced-free page toggle.
module clock_display_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic [7:0]  sec_bcd,
    input  logic [7:0]  min_bcd,
    input  logic [7:0]  hour_bcd,
    input  logic [7:0]  day_bcd,
    input  logic [7:0]  month_bcd,
    input  logic [15:0] year_bcd,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic        page,
    output logic        frame_start,
    output logic        bcd_err
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic {
        PAGE_TIME = 1'b0,
        PAGE_DATE = 1'b1
    } page_e;

    typedef struct packed {
        logic [7:0]  sec;
        logic [7:0]  min;
        logic [7:0]  hour;
        logic [7:0]  day;
        logic [7:0]  month;
        logic [15:0] year;
    } snap_t;

    // Lit-segment pattern {g..a}; non-decimal nibbles light nothing.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        pat = 7'h00;
        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_digit_idx;
    page_e            r_page;
    logic             r_pending;
    logic             r_mode_s1;
    logic             r_mode_s2;
    logic             r_mode_prev;
    snap_t            r_snap;
    logic [6:0]       r_seg_n;
    logic             r_dp_n;
    logic [7:0]       r_an_n;
    logic             r_frame_start;
    logic             r_bcd_err;

    logic             w_tick;
    logic             w_frame_end;
    logic             w_mode_rise;
    logic [2:0]       w_idx_next;
    snap_t            w_snap_next;
    page_e            w_page_next;
    logic [3:0]       w_nib;
    logic             w_blank;
    logic             w_dp;
    logic             w_bad_nib;
    logic [7:0]       w_an_next;
    logic [6:0]       w_seg_next;
    logic             w_dp_n_next;

    assign w_tick      = (r_div_cnt == DIV_LAST);
    assign w_frame_end = w_tick && (r_digit_idx == 3'd7);
    assign w_mode_rise = r_mode_s2 && !r_mode_prev;
    assign w_idx_next  = r_digit_idx + 3'd1;

    // The decoded digit uses snapshot/page as they will be after this tick,
    // so a page change lands exactly on digit 0 of the new frame.
    assign w_snap_next = w_frame_end ? '{sec: sec_bcd, min: min_bcd, hour: hour_bcd,
                                         day: day_bcd, month: month_bcd, year: year_bcd}
                                     : r_snap;
    assign w_page_next = w_frame_end ? page_e'(r_page ^ r_pending) : r_page;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_s1   <= 1'b0;
            r_mode_s2   <= 1'b0;
            r_mode_prev <= 1'b0;
        end else begin
            r_mode_s1   <= mode;
            r_mode_s2   <= r_mode_s1;
            r_mode_prev <= r_mode_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt   <= '0;
            r_digit_idx <= 3'd0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            if (w_tick) begin
                r_digit_idx <= w_idx_next;
            end
        end
    end

    // A rise seen in the boundary cycle re-arms pending rather than being dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_page    <= PAGE_TIME;
            r_pending <= 1'b0;
        end else if (w_frame_end) begin
            r_page    <= w_page_next;
            r_pending <= w_mode_rise;
        end else if (w_mode_rise) begin
            r_pending <= 1'b1;
        end
    end

    // NOTE: the snapshot bank is reset because the first frame after reset displays it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else begin
            r_snap <= w_snap_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_nib   = 4'h0;
        w_blank = 1'b0;
        w_dp    = 1'b0;
        if (w_page_next == PAGE_TIME) begin
            case (w_idx_next)
                3'd0: w_nib = w_snap_next.sec[3:0];
                3'd1: w_nib = w_snap_next.sec[7:4];
                3'd2: begin
                    w_nib = w_snap_next.min[3:0];
                    w_dp  = 1'b1;
                end
                3'd3: w_nib = w_snap_next.min[7:4];
                3'd4: begin
                    w_nib = w_snap_next.hour[3:0];
                    w_dp  = 1'b1;
                end
                3'd5: begin
                    w_nib   = w_snap_next.hour[7:4];
                    w_blank = BLANK_LEAD && (w_snap_next.hour[7:4] == 4'h0);
                end
                default: w_blank = 1'b1;
            endcase
        end else begin
            case (w_idx_next)
                3'd0: w_nib = w_snap_next.year[3:0];
                3'd1: w_nib = w_snap_next.year[7:4];
                3'd2: w_nib = w_snap_next.year[11:8];
                3'd3: w_nib = w_snap_next.year[15:12];
                3'd4: begin
                    w_nib = w_snap_next.month[3:0];
                    w_dp  = 1'b1;
                end
                3'd5: w_nib = w_snap_next.month[7:4];
                3'd6: begin
                    w_nib = w_snap_next.day[3:0];
                    w_dp  = 1'b1;
                end
                default: begin
                    w_nib   = w_snap_next.day[7:4];
                    w_blank = BLANK_LEAD && (w_snap_next.day[7:4] == 4'h0);
                end
            endcase
        end
    end

    assign w_bad_nib   = !w_blank && (w_nib > 4'd9);
    assign w_an_next   = w_blank ? 8'hFF : ~(8'd1 << w_idx_next);
    assign w_seg_next  = w_blank ? 7'h7F : ~seg_decode(w_nib);
    assign w_dp_n_next = ~(w_dp && !w_blank);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_n        <= 8'hFF;
            r_seg_n       <= 7'h7F;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
            r_bcd_err     <= 1'b0;
        end else begin
            r_frame_start <= w_frame_end;
            if (w_tick) begin
                r_an_n    <= w_an_next;
                r_seg_n   <= w_seg_next;
                r_dp_n    <= w_dp_n_next;
                r_bcd_err <= r_bcd_err | w_bad_nib;
            end
        end
    end

    assign seg_n       = r_seg_n;
    assign dp_n        = r_dp_n;
    assign an_n        = r_an_n;
    assign page        = r_page;
    assign frame_start = r_frame_start;
    assign bcd_err     = r_bcd_err;

    a_anode_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (an_n == 8'hFF) || $onehot(~an_n));

    a_frame_on_idx0: assert property (@(posedge clk) disable iff (!rst_n)
        frame_start |-> (r_digit_idx == 3'd0));

    a_err_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        bcd_err |=> bcd_err);

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: random BCD/mode stimulus, a frame-level reference model
// feeding a scoreboard queue, and a monitor comparing two DUTs (leading blank on and off).
module tb_clock_display_scan;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 8 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  sec_bcd = 8'h58;
    logic [7:0]  min_bcd = 8'h59;
    logic [7:0]  hour_bcd = 8'h23;
    logic [7:0]  day_bcd = 8'h09;
    logic [7:0]  month_bcd = 8'h03;
    logic [15:0] year_bcd = 16'h2024;

    logic [6:0]  seg_n_b, seg_n_s;
    logic        dp_n_b, dp_n_s;
    logic [7:0]  an_n_b, an_n_s;
    logic        page_b, page_s;
    logic        fs_b, fs_s;
    logic        err_b, err_s;

    always #5 clk = ~clk;

    clock_display_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_LEAD(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd),
        .day_bcd(day_bcd), .month_bcd(month_bcd), .year_bcd(year_bcd),
        .seg_n(seg_n_b), .dp_n(dp_n_b), .an_n(an_n_b),
        .page(page_b), .frame_start(fs_b), .bcd_err(err_b)
    );

    clock_display_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_LEAD(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd),
        .day_bcd(day_bcd), .month_bcd(month_bcd), .year_bcd(year_bcd),
        .seg_n(seg_n_s), .dp_n(dp_n_s), .an_n(an_n_s),
        .page(page_s), .frame_start(fs_s), .bcd_err(err_s)
    );

    typedef struct {
        int         slot;
        logic [7:0] an_b;
        logic [6:0] seg_b;
        logic       dp_b;
        logic [7:0] an_s;
        logic [6:0] seg_s;
        logic       dp_s;
        logic       pg;
        logic       bad;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // {an_n, seg_n, dp_n} for one glyph; v < 0 means a dark digit.
    function automatic logic [15:0] glyph(input int v, input int k, input bit dp);
        logic [7:0] an;
        logic [6:0] seg;
        if (v < 0) return {8'hFF, 7'h7F, 1'b1};
        an  = ~(8'd1 << k);
        seg = (v > 9) ? 7'h7F : ~seg_tab[v];
        return {an, seg, ~dp};
    endfunction

    function automatic exp_t ref_digit(input int slot, input logic [7:0] s, input logic [7:0] mi,
                                       input logic [7:0] h, input logic [7:0] d, input logic [7:0] mo,
                                       input logic [15:0] y, input logic pg);
        int   nib [8];
        int   k, lead, dpa, dpb, v_lead;
        bit   dp;
        exp_t e;
        k = slot % 8;
        if (pg == 1'b0) begin
            nib  = '{int'(s[3:0]), int'(s[7:4]), int'(mi[3:0]), int'(mi[7:4]),
                     int'(h[3:0]), int'(h[7:4]), -1, -1};
            lead = 5; dpa = 2; dpb = 4;
        end else begin
            nib  = '{int'(y[3:0]), int'(y[7:4]), int'(y[11:8]), int'(y[15:12]),
                     int'(mo[3:0]), int'(mo[7:4]), int'(d[3:0]), int'(d[7:4])};
            lead = 7; dpa = 4; dpb = 6;
        end
        dp     = (k == dpa) || (k == dpb);
        v_lead = (k == lead && nib[k] == 0) ? -1 : nib[k];
        e.slot = slot;
        e.pg   = pg;
        e.bad  = (nib[k] > 9);
        {e.an_s, e.seg_s, e.dp_s} = glyph(nib[k], k, dp);
        {e.an_b, e.seg_b, e.dp_b} = glyph(v_lead, k, dp);
        return e;
    endfunction

    // Reference model: edges counted since reset release; display slot s starts at edge
    // s*SCAN_DIV, frame f's content is sampled at edge f*FRAME; a mode rise first sampled at
    // edge e toggles the page at the first frame edge >= e+3.
    int   cyc = 0;
    logic mode_prev_m = 1'b0;
    logic page_m = 1'b0;
    bit   toggle_at [int];

    always @(posedge clk) begin
        if (!rst_n) begin
            cyc         = 0;
            mode_prev_m = 1'b0;
            page_m      = 1'b0;
            toggle_at.delete();
            sb_q.delete();
            for (int k = 1; k < 8; k++)
                sb_q.push_back(ref_digit(k, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0));
        end else begin
            cyc++;
            if (mode && !mode_prev_m)
                toggle_at[((cyc + 3 + FRAME - 1) / FRAME) * FRAME] = 1'b1;
            mode_prev_m = mode;
            if (cyc % FRAME == 0) begin
                if (toggle_at.exists(cyc)) page_m = ~page_m;
                for (int k = 0; k < 8; k++)
                    sb_q.push_back(ref_digit(cyc / SCAN_DIV + k, sec_bcd, min_bcd, hour_bcd,
                                             day_bcd, month_bcd, year_bcd, page_m));
            end
        end
    end

    exp_t cur;
    bit   have_cur = 1'b0;
    logic exp_err = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            have_cur = 1'b0;
            exp_err  = 1'b0;
        end else begin
            if (cyc > 0 && cyc % SCAN_DIV == 0) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd0, 32'd1);
                end else begin
                    cur      = sb_q.pop_front();
                    have_cur = 1'b1;
                    check("slot_order", cur.slot, cyc / SCAN_DIV);
                    if (cur.bad) exp_err = 1'b1;
                end
            end
            if (!have_cur) begin
                check("dark_an_n_b", an_n_b, 8'hFF);
                check("dark_seg_n_b", seg_n_b, 7'h7F);
                check("dark_dp_n_b", dp_n_b, 1'b1);
                check("dark_an_n_s", an_n_s, 8'hFF);
                check("dark_seg_n_s", seg_n_s, 7'h7F);
                check("dark_dp_n_s", dp_n_s, 1'b1);
                check("dark_page", page_b, 1'b0);
            end else begin
                check("an_n_b", an_n_b, cur.an_b);
                check("seg_n_b", seg_n_b, cur.seg_b);
                check("dp_n_b", dp_n_b, cur.dp_b);
                check("an_n_s", an_n_s, cur.an_s);
                check("seg_n_s", seg_n_s, cur.seg_s);
                check("dp_n_s", dp_n_s, cur.dp_s);
                check("page_b", page_b, cur.pg);
                check("page_s", page_s, cur.pg);
            end
            check("frame_start_b", fs_b, (cyc % FRAME == 0) ? 1'b1 : 1'b0);
            check("frame_start_s", fs_s, (cyc % FRAME == 0) ? 1'b1 : 1'b0);
            check("bcd_err_b", err_b, exp_err);
            check("bcd_err_s", err_s, exp_err);
        end
    end

    function automatic logic [7:0] to_bcd2(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic randomize_one();
        case ($urandom_range(0, 5))
            0: sec_bcd   = to_bcd2($urandom_range(0, 59));
            1: min_bcd   = to_bcd2($urandom_range(0, 59));
            2: hour_bcd  = to_bcd2($urandom_range(0, 23));
            3: day_bcd   = to_bcd2($urandom_range(1, 31));
            4: month_bcd = to_bcd2($urandom_range(1, 12));
            default: year_bcd = {to_bcd2($urandom_range(19, 20)), to_bcd2($urandom_range(0, 99))};
        endcase
    endtask

    task automatic pulse_mode();
        mode = 1'b1;
        repeat (2) @(negedge clk);
        mode = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_phase(input int r);
        bit found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(negedge clk);
            if (cyc % FRAME == r) found = 1'b1;
        end
        if (!found) check("wait_phase_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_random(input int n_cycles, input int mode_rate);
        int pulse_left = 0;
        int gap = 0;
        for (int i = 0; i < n_cycles; i++) begin
            @(negedge clk);
            if (pulse_left > 0) begin
                pulse_left--;
                if (pulse_left == 0) begin
                    mode = 1'b0;
                    gap  = 3;
                end
            end else if (gap > 0) begin
                gap--;
            end else if (mode_rate > 0 && $urandom_range(0, mode_rate) == 0) begin
                mode       = 1'b1;
                pulse_left = 2;
            end
            if ($urandom_range(0, 5) == 0) randomize_one();
        end
        mode = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 23:59:58 across three frames, then a leading-zero hour.
        repeat (3 * FRAME) @(negedge clk);
        hour_bcd = 8'h07;
        repeat (2 * FRAME) @(negedge clk);

        // Switch to DATE (09/03/2024) and let two frames play.
        pulse_mode();
        repeat (2 * FRAME) @(negedge clk);

        // Two pulses within one frame give a single toggle.
        wait_phase(4);
        pulse_mode();
        pulse_mode();
        repeat (2 * FRAME) @(negedge clk);

        // Rise detected in the boundary cycle itself.
        wait_phase(FRAME - 3);
        pulse_mode();
        repeat (3 * FRAME) @(negedge clk);

        // Random inputs changing mid-frame with random mode pulses.
        run_random(14 * FRAME, 40);

        // Non-decimal seconds nibble sets the sticky error.
        wait_phase(10);
        sec_bcd = 8'h0A;
        repeat (FRAME) @(negedge clk);
        run_random(2 * FRAME, 0);
        if (page_m == 1'b0) begin
            pulse_mode();
            repeat (2 * FRAME) @(negedge clk);
        end

        // Asynchronous reset while digit 3 is on.
        wait_phase(13);
        #1 rst_n = 1'b0;
        #1;
        check("rst_an_n", an_n_b, 8'hFF);
        check("rst_seg_n", seg_n_b, 7'h7F);
        check("rst_dp_n", dp_n_b, 1'b1);
        check("rst_page", page_b, 1'b0);
        check("rst_frame_start", fs_b, 1'b0);
        check("rst_bcd_err", err_b, 1'b0);
        check("rst_bcd_err_s", err_s, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_random(3 * FRAME, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
